// File: rtl/writeback_controller.sv
// Dirty-line writeback: streams a captured 128-bit block as a 4-beat word burst.
// Optional WB_PENDING_QUEUE_EN adds a one-deep pending request and o_pending.
module writeback_controller #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wb_en,
    input  logic [ADDR_BITS-5:0] i_base_addr,
    input  logic [127:0]         i_data_block,
    input  logic                 ready_mm,
    output logic                 o_wr_en,
    output logic [ADDR_BITS-3:0] o_addr_to_mem,
    output logic [31:0]          o_data_to_mem,
    output logic                 o_busy,
    output logic                 o_done,
`ifdef WB_PENDING_QUEUE_EN
    output logic                 o_pending,
`endif
    output logic [2:0]           counter_probe
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-5:0] base_q, base_d;
    logic [127:0]         blk_q, blk_d;
    logic [31:0]          word;

`ifdef WB_PENDING_QUEUE_EN
    logic                 pv_q, pv_d;
    logic [ADDR_BITS-5:0] pbase_q, pbase_d;
    logic [127:0]         pblk_q, pblk_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        blk_d   = blk_q;
`ifdef WB_PENDING_QUEUE_EN
        pv_d    = pv_q;
        pbase_d = pbase_q;
        pblk_d  = pblk_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_wb_en) begin
                    state_d = S_WRITE;
                    cnt_d   = 2'd0;
                    base_d  = i_base_addr;
                    blk_d   = i_data_block;
                end
            end
            S_WRITE: begin
                if (ready_mm) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef WB_PENDING_QUEUE_EN
                // Back-to-back eviction: skip IDLE when a request is queued
                if (pv_q) begin
                    state_d = S_WRITE;
                    cnt_d   = 2'd0;
                    base_d  = pbase_q;
                    blk_d   = pblk_q;
                    pv_d    = 1'b0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
`ifdef WB_PENDING_QUEUE_EN
        if (state_q != S_IDLE && i_wb_en && !pv_q) begin
            pv_d    = 1'b1;
            pbase_d = i_base_addr;
            pblk_d  = i_data_block;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            base_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            blk_q   <= blk_d;
        end
    end

`ifdef WB_PENDING_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q    <= 1'b0;
            pbase_q <= '0;
            pblk_q  <= '0;
        end else begin
            pv_q    <= pv_d;
            pbase_q <= pbase_d;
            pblk_q  <= pblk_d;
        end
    end

    assign o_pending = pv_q;
`endif

    // Word 0 sits in the most significant lane, matching the refill packing
    always_comb begin
        word = blk_q[127:96];
        unique case (cnt_q)
            2'd0: word = blk_q[127:96];
            2'd1: word = blk_q[95:64];
            2'd2: word = blk_q[63:32];
            2'd3: word = blk_q[31:0];
            default: word = blk_q[127:96];
        endcase
    end

    assign o_wr_en       = (state_q == S_WRITE);
    assign o_done        = (state_q == S_DONE);
    assign o_busy        = o_wr_en | o_done;
    assign o_addr_to_mem = o_wr_en ? {base_q, cnt_q} : '0;
    assign o_data_to_mem = o_wr_en ? word : '0;
    assign counter_probe = {o_wr_en, cnt_q};

endmodule

// File: tb/tb_writeback_controller.sv
// Bench for writeback_controller: vector table, hand sequences, random bursts
// checked against a queue-of-words reference model.
module tb_writeback_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_wb_en;
    logic [7:0]   i_base_addr;
    logic [127:0] i_data_block;
    logic         ready_mm;
    logic         o_wr_en;
    logic [9:0]   o_addr_to_mem;
    logic [31:0]  o_data_to_mem;
    logic         o_busy;
    logic         o_done;
    logic [2:0]   counter_probe;
`ifdef WB_PENDING_QUEUE_EN
    logic         o_pending;
`endif

    int tests = 0;
    int fails = 0;

    writeback_controller #(.ADDR_BITS(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wb_en       (i_wb_en),
        .i_base_addr   (i_base_addr),
        .i_data_block  (i_data_block),
        .ready_mm      (ready_mm),
        .o_wr_en       (o_wr_en),
        .o_addr_to_mem (o_addr_to_mem),
        .o_data_to_mem (o_data_to_mem),
        .o_busy        (o_busy),
        .o_done        (o_done),
`ifdef WB_PENDING_QUEUE_EN
        .o_pending     (o_pending),
`endif
        .counter_probe (counter_probe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [7:0]   base;
        logic [127:0] blk;
        logic         rdy;
        logic [47:0]  exp;
    } vec_t;

    vec_t tbl[$];

    localparam logic [127:0] BLK =
        128'h11111111_22222222_33333333_44444444;

    function automatic logic [31:0] wsel(logic [127:0] b, int i);
        logic [127:0] t;
        t = b >> (96 - 32 * i);
        return t[31:0];
    endfunction

    // Expected {wr, addr, data, busy, done, probe}; kind 0=idle 1=beat 2=done
    function automatic logic [47:0] expect_out(int kind, int idx,
                                               logic [7:0] b,
                                               logic [127:0] blk);
        logic [1:0] ix;
        ix = idx[1:0];
        if (kind == 1)
            return {1'b1, b, ix, wsel(blk, idx), 1'b1, 1'b0, 1'b1, ix};
        if (kind == 2)
            return {1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 3'd0};
        return 48'd0;
    endfunction

    function automatic vec_t mk(logic en, logic [7:0] b, logic [127:0] blk,
                                logic rdy, int kind, int idx);
        vec_t v;
        v.en   = en;
        v.base = b;
        v.blk  = blk;
        v.rdy  = rdy;
        v.exp  = expect_out(kind, idx, 8'h2A, BLK);
        return v;
    endfunction

    function automatic logic [47:0] outs();
        return {o_wr_en, o_addr_to_mem, o_data_to_mem,
                o_busy, o_done, counter_probe};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst; the model is the list of 4 words the block must emit
    task automatic run_burst(logic [7:0] b, logic [127:0] blk,
                             bit rnd_ready, bit noise, bit scramble);
        int  idx;
        bit  got_done;
        i_wb_en      = 1'b1;
        i_base_addr  = b;
        i_data_block = blk;
        tick();
        i_wb_en = 1'b0;
        if (scramble) begin
            i_data_block = $urandom();
            i_base_addr  = 8'($urandom());
        end
        idx      = 0;
        got_done = 0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            if (o_wr_en) begin
                chk("beat", {o_busy, counter_probe, o_addr_to_mem, o_data_to_mem},
                    {1'b1, 1'b1, 2'(idx), b, 2'(idx), wsel(blk, idx)});
            end else if (o_done) begin
                chk("beats_before_done", 64'(idx), 64'd4);
                got_done = 1;
            end else begin
                chk("unexpected_idle", outs(), 48'hFFFF_FFFF_FFFF);
                break;
            end
            if (!got_done) begin
                ready_mm = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (noise && cyc == 0) begin
                    i_wb_en     = 1'b1;
                    i_base_addr = 8'h05;
                end else begin
                    i_wb_en = 1'b0;
                end
                @(posedge clk);
                if (o_wr_en && ready_mm) idx++;
                #1;
            end
        end
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
        ready_mm = 1'b0;
        i_wb_en  = 1'b0;
`ifdef WB_PENDING_QUEUE_EN
        if (noise) begin
            chk("pending_set", 64'(o_pending), 64'd1);
            tick();
            chk("queued_start", {o_wr_en, o_addr_to_mem}, {1'b1, 10'h014});
            ready_mm = 1'b1;
            for (int k = 0; k < 20 && !o_done; k++) tick();
            ready_mm = 1'b0;
        end
`endif
        tick();
        chk("post_burst_idle", outs(), 48'd0);
    endtask

    initial begin
        rst          = 1'b1;
        i_wb_en      = 1'b0;
        i_base_addr  = '0;
        i_data_block = '0;
        ready_mm     = 1'b0;

        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 8'h00, 128'd0, 1'(i), 0, 0));
        tbl.push_back(mk(1, 8'h2A, BLK, 1, 1, 0));
        for (int i = 1; i < 4; i++)
            tbl.push_back(mk(0, 8'h00, BLK, 1, 1, i));
        tbl.push_back(mk(0, 8'h00, BLK, 1, 2, 0));
        tbl.push_back(mk(0, 8'h00, BLK, 1, 0, 0));
        tbl.push_back(mk(1, 8'h2A, BLK, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 128'd0, 1, 1, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 8'h00, 128'd0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 128'd0, 1, 1, 2));
        tbl.push_back(mk(0, 8'h00, 128'd0, 1, 1, 3));
        tbl.push_back(mk(0, 8'h00, 128'd0, 1, 2, 0));
        tbl.push_back(mk(0, 8'h00, 128'd0, 1, 0, 0));

        #12;
        chk("reset_outputs", outs(), 48'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            i_wb_en      = tbl[i].en;
            i_base_addr  = tbl[i].base;
            i_data_block = tbl[i].blk;
            ready_mm     = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        i_wb_en  = 1'b0;
        ready_mm = 1'b0;

        run_burst(8'h2A, BLK, 0, 1, 0);

        i_wb_en      = 1'b1;
        i_base_addr  = 8'h2A;
        i_data_block = BLK;
        ready_mm     = 1'b1;
        tick();
        i_wb_en = 1'b0;
        tick();
        tick();
        chk("pre_reset_beat3", {o_wr_en, o_addr_to_mem}, {1'b1, 10'h0AA});
        #2;
        rst = 1'b1;
        #1;
        chk("async_abort", {o_wr_en, o_busy, o_done}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_reset", outs(), 48'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        ready_mm = 1'b0;
        tick();
        chk("no_done_after_abort", outs(), 48'd0);
        run_burst(8'h2A, BLK, 0, 0, 0);

        for (int n = 0; n < 40; n++)
            run_burst(8'($urandom()), {$urandom(), $urandom(), $urandom(), $urandom()},
                      1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
